hdmi_src_arb: RTL and testbench

Frame-granular arbiter and sequencer for the HDMI video input. Shares the `hdmi` block's pixel port (`r`, `g`, `b`, `video_valid`, `video_rdy`) between two pixel requesters:

- source 0: GPU scan-out, priority;
- source 1: debug/overlay stream.

Ownership changes only at frame boundaries. When no source requests, or a granted source stalls, the block falls back to an internal colour-bar pattern or black fill, so the HDMI transmitter is never starved mid-frame.

---
 rtl/hdmi_pkg.sv | 41 ++++
 rtl/colorbar_gen.sv | 19 +
 rtl/hdmi_src_arb.sv | 148 ++++++++++++++
 tb/tb_hdmi_src_arb.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// Shared types and colour-bar constants for the HDMI source arbiter and pattern generators.
package hdmi_pkg;

  typedef enum logic [1:0] {
    GNT_PAT  = 2'b00,
    GNT_SRC0 = 2'b01,
    GNT_SRC1 = 2'b10
  } grant_t;

  typedef enum logic [1:0] {
    ARB,
    STREAM,
    PATTERN,
    FILL
  } arb_state_t;

  localparam bit [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam bit [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam bit [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam bit [23:0] BAR_GREEN   = 24'h00FF00;
  localparam bit [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam bit [23:0] BAR_RED     = 24'hFF0000;
  localparam bit [23:0] BAR_BLUE    = 24'h0000FF;
  localparam bit [23:0] BAR_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    logic [23:0] rgb;
    unique case (idx)
      3'd0: rgb = BAR_WHITE;
      3'd1: rgb = BAR_YELLOW;
      3'd2: rgb = BAR_CYAN;
      3'd3: rgb = BAR_GREEN;
      3'd4: rgb = BAR_MAGENTA;
      3'd5: rgb = BAR_RED;
      3'd6: rgb = BAR_BLUE;
      3'd7: rgb = BAR_BLACK;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/colorbar_gen.sv
// Eight-bar vertical colour pattern: maps a column index to its bar colour.
module colorbar_gen
  import hdmi_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned COL_W    = $clog2(H_ACTIVE)
) (
  input  logic [COL_W-1:0] col,
  output logic [23:0]      rgb
);

  localparam int unsigned BAR_W = H_ACTIVE / 8;

  // col < H_ACTIVE, so the quotient always fits in three bits.
  logic [2:0] bar;
  assign bar = 3'(col / COL_W'(BAR_W));
  assign rgb = bar_rgb(bar);

endmodule

// File: rtl/hdmi_src_arb.sv
// Frame-granular arbiter between two pixel sources and an internal pattern/black fill,
// driving the pixel port of the hdmi block.
module hdmi_src_arb
  import hdmi_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned STALL_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        src0_req,
  input  logic [23:0] src0_rgb,
  input  logic        src0_valid,
  output logic        src0_rdy,
  input  logic        src1_req,
  input  logic [23:0] src1_rgb,
  input  logic        src1_valid,
  output logic        src1_rdy,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        video_valid,
  input  logic        video_rdy,
  output logic [1:0]  grant,
  output logic        frame_done,
  output logic        stall_err
);

  localparam int unsigned CW = $clog2(H_ACTIVE);
  localparam int unsigned RW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int unsigned SW = $clog2(STALL_LIMIT + 1);

  arb_state_t    state_q;
  grant_t        grant_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [SW-1:0] stall_q;
  logic          frame_done_q;
  logic          stall_err_q;

  logic [23:0] pat_rgb;
  logic [23:0] out_rgb;
  logic        xfer;
  logic        starve;
  logic        last_px;

  colorbar_gen #(
    .H_ACTIVE(H_ACTIVE),
    .COL_W   (CW)
  ) u_colorbar (
    .col(col_q),
    .rgb(pat_rgb)
  );

  // Output mux: STREAM is a zero-latency pass-through of the granted source.
  always_comb begin
    video_valid = 1'b0;
    src0_rdy    = 1'b0;
    src1_rdy    = 1'b0;
    out_rgb     = '0;
    unique case (state_q)
      ARB: ;
      STREAM: begin
        if (grant_q == GNT_SRC1) begin
          video_valid = src1_valid;
          src1_rdy    = video_rdy;
          out_rgb     = src1_rgb;
        end else begin
          video_valid = src0_valid;
          src0_rdy    = video_rdy;
          out_rgb     = src0_rgb;
        end
      end
      PATTERN: begin
        video_valid = 1'b1;
        out_rgb     = pat_rgb;
      end
      FILL: begin
        video_valid = 1'b1;
      end
    endcase
  end

  assign {r, g, b}   = out_rgb;
  assign grant       = grant_q;
  assign frame_done  = frame_done_q;
  assign stall_err   = stall_err_q;

  assign xfer    = video_valid & video_rdy;
  // A low video_rdy is back-pressure from the sink, never a source stall.
  assign starve  = (state_q == STREAM) & video_rdy & ~video_valid;
  assign last_px = (col_q == CW'(H_ACTIVE - 1)) && (row_q == RW'(V_ACTIVE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB;
      grant_q      <= GNT_PAT;
      col_q        <= '0;
      row_q        <= '0;
      stall_q      <= '0;
      frame_done_q <= 1'b0;
      stall_err_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      stall_err_q  <= 1'b0;
      unique case (state_q)
        ARB: begin
          if (src0_req) begin
            grant_q <= GNT_SRC0;
            state_q <= STREAM;
          end else if (src1_req) begin
            grant_q <= GNT_SRC1;
            state_q <= STREAM;
          end else begin
            grant_q <= GNT_PAT;
            state_q <= PATTERN;
          end
        end
        STREAM, PATTERN, FILL: begin
          if (xfer) begin
            stall_q <= '0;
            if (col_q == CW'(H_ACTIVE - 1)) begin
              col_q <= '0;
              row_q <= (row_q == RW'(V_ACTIVE - 1)) ? '0 : row_q + RW'(1);
            end else begin
              col_q <= col_q + CW'(1);
            end
            if (last_px) begin
              state_q      <= ARB;
              frame_done_q <= 1'b1;
            end
          end else if (starve) begin
            // Abandon the source; FILL finishes the frame from the current position.
            if (stall_q == SW'(STALL_LIMIT - 1)) begin
              stall_q     <= '0;
              state_q     <= FILL;
              stall_err_q <= 1'b1;
            end else begin
              stall_q <= stall_q + SW'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_src_arb.sv
// Directed bench for hdmi_src_arb with a pixel scoreboard filled ahead of each frame.
module tb_hdmi_src_arb;

  localparam int unsigned H   = 16;
  localparam int unsigned V   = 4;
  localparam int unsigned SL  = 8;
  localparam int          NPX = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        src0_req = 1'b0, src0_valid = 1'b0, src0_rdy;
  logic        src1_req = 1'b0, src1_valid = 1'b0, src1_rdy;
  logic [23:0] src0_rgb = '0, src1_rgb = '0;
  logic [7:0]  r, g, b;
  logic        video_valid;
  logic        video_rdy = 1'b1;
  logic [1:0]  grant;
  logic        frame_done, stall_err;

  always #5 clk = ~clk;

  hdmi_src_arb #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .STALL_LIMIT(SL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .src0_req   (src0_req),
    .src0_rgb   (src0_rgb),
    .src0_valid (src0_valid),
    .src0_rdy   (src0_rdy),
    .src1_req   (src1_req),
    .src1_rgb   (src1_rgb),
    .src1_valid (src1_valid),
    .src1_rdy   (src1_rdy),
    .r          (r),
    .g          (g),
    .b          (b),
    .video_valid(video_valid),
    .video_rdy  (video_rdy),
    .grant      (grant),
    .frame_done (frame_done),
    .stall_err  (stall_err)
  );

  int tests = 0;
  int fails = 0;
  logic [23:0] exp_q[$];
  int px = 0, last_px = 0, fd_cnt = 0, st_cnt = 0;
  int k0 = 0, k1 = 0, starve_run = 0;
  bit idle0 = 1'b0, idle1 = 1'b0, fill_mode = 1'b0, rnd = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] src_px(input int id, input int k);
    logic [23:0] base;
    base = (id == 0) ? 24'hA00000 : 24'h500000;
    return base | (24'(k) & 24'h00FFFF);
  endfunction

  function automatic logic [23:0] bar_exp(input int col);
    case (col / 2)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic push_pattern();
    for (int i = 0; i < NPX; i++) exp_q.push_back(bar_exp(i % H));
  endtask

  task automatic push_src(input int id, input int n, input int k);
    for (int i = 0; i < n; i++) exp_q.push_back(src_px(id, k + i));
  endtask

  task automatic push_zero(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(24'h000000);
  endtask

  // Samples the DUT before the rising edge that would complete a transfer.
  task automatic monitor();
    logic [23:0] e;
    if (video_valid && video_rdy) begin
      tests++;
      assert (exp_q.size() != 0)
      else begin
        fails++;
        $error("FAIL sb_underflow: observed transfer %0h expected none", {r, g, b});
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pixel", 32'({r, g, b}), 32'(e));
      end
      px++;
    end
    if (src0_valid && src0_rdy) begin
      chk("acc0_is_xfer", 32'(video_valid && video_rdy), 1);
      k0++;
    end
    if (src1_valid && src1_rdy) begin
      chk("acc1_is_xfer", 32'(video_valid && video_rdy), 1);
      k1++;
    end
    if (idle0) chk("src0_rdy_idle", 32'(src0_rdy), 0);
    if (idle1) chk("src1_rdy_idle", 32'(src1_rdy), 0);
    if (fill_mode) chk("fill_rdy", 32'({src0_rdy, src1_rdy}), 0);
    if (stall_err) begin
      st_cnt++;
      fill_mode = 1'b1;
    end
    if (frame_done) begin
      fd_cnt++;
      last_px = px;
      px = 0;
      fill_mode = 1'b0;
      chk("gap_valid", 32'(video_valid), 0);
    end
    if (rnd) starve_run = (video_rdy && !src1_valid) ? starve_run + 1 : 0;
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    src0_rgb = src_px(0, k0);
    src1_rgb = src_px(1, k1);
    @(posedge clk);
    #1;
    if (rnd) begin
      video_rdy  = ($urandom_range(0, 3) != 0);
      // Keep the random stream clear of the stall limit.
      src1_valid = (starve_run >= 5) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic run_until_px(input int n);
    int budget = 0;
    while (px < n && budget < 2000) begin
      cyc();
      budget++;
    end
    chk("px_reached", 32'(px >= n), 1);
  endtask

  task automatic run_frame();
    int f = fd_cnt;
    int budget = 0;
    while (fd_cnt == f && budget < 3000) begin
      cyc();
      budget++;
    end
    chk("frame_done_seen", fd_cnt, f + 1);
    chk("frame_px", last_px, NPX);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(video_valid), 0);
    chk({tag, "_rdy"}, 32'({src0_rdy, src1_rdy}), 0);
    chk({tag, "_rgb"}, 32'({r, g, b}), 0);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_stall_err"}, 32'(stall_err), 0);
  endtask

  initial begin
    int s;
    int p;

    // Reset, then a pattern frame with no requests.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    idle0 = 1'b1;
    idle1 = 1'b1;
    push_pattern();
    rst = 1'b0;
    @(negedge clk);
    chk("arb_valid", 32'(video_valid), 0);
    @(posedge clk);
    #1;
    chk("grant_pat", 32'(grant), 0);
    run_until_px(5);
    // Requests mid-frame must not pre-empt the pattern.
    src0_req   = 1'b1;
    src1_req   = 1'b1;
    src0_valid = 1'b1;
    src1_valid = 1'b1;
    run_frame();

    // src0 wins; dropping its request mid-frame still finishes the frame.
    chk("grant_src0", 32'(grant), 1);
    idle0 = 1'b0;
    push_src(0, NPX, k0);
    run_until_px(10);
    src0_req = 1'b0;
    run_frame();

    // src1 frame with random source valid and sink ready.
    chk("grant_src1", 32'(grant), 2);
    idle0 = 1'b1;
    idle1 = 1'b0;
    push_src(1, NPX, k1);
    src1_req = 1'b0;
    src0_req = 1'b1;
    rnd = 1'b1;
    s = st_cnt;
    run_frame();
    rnd = 1'b0;
    video_rdy  = 1'b1;
    src1_valid = 1'b1;
    chk("rand_no_stall", st_cnt - s, 0);

    // src0 stalls at pixel 20; black fill completes the frame.
    chk("grant_src0_b", 32'(grant), 1);
    idle0 = 1'b0;
    idle1 = 1'b1;
    push_src(0, 20, k0);
    push_zero(NPX - 20);
    src0_req = 1'b0;
    s = st_cnt;
    run_until_px(20);
    src0_valid = 1'b0;
    run_frame();
    chk("stall_err_once", st_cnt - s, 1);

    // Re-arbitration gives the pattern; hold the sink off mid-frame.
    chk("grant_rearb", 32'(grant), 0);
    idle0 = 1'b1;
    src0_valid = 1'b1;
    push_pattern();
    run_until_px(26);
    video_rdy = 1'b0;
    p = px;
    repeat (50) cyc();
    chk("hold_rgb", 32'({r, g, b}), 32'(24'hFF0000));
    chk("hold_px", px, p);
    video_rdy = 1'b1;
    src0_req  = 1'b1;
    run_frame();

    // Sink and source both idle in STREAM: not a stall.
    chk("grant_src0_c", 32'(grant), 1);
    idle0 = 1'b0;
    push_src(0, NPX, k0);
    src0_req = 1'b0;
    src1_req = 1'b1;
    run_until_px(30);
    video_rdy  = 1'b0;
    src0_valid = 1'b0;
    s = st_cnt;
    repeat (50) cyc();
    chk("rdy_low_no_stall", st_cnt - s, 0);
    chk("rdy_low_px", px, 30);
    src0_valid = 1'b1;
    video_rdy  = 1'b1;
    run_frame();

    // Reset in the middle of a src1 frame.
    chk("grant_src1_b", 32'(grant), 2);
    idle0 = 1'b1;
    idle1 = 1'b0;
    push_src(1, NPX, k1);
    src1_req = 1'b0;
    run_until_px(33);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    px = 0;
    fill_mode = 1'b0;
    idle1 = 1'b1;
    push_pattern();
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_arb", 32'(video_valid), 0);
    @(posedge clk);
    #1;
    run_frame();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
